// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, default timing constants and the
// scan-code prefixes the downstream decoder keys on.
package ps2_pkg;

  localparam int PS2_BITS           = 8;
  localparam int PS2_FILTER_LEN_DEF = 8;
  localparam int PS2_TIMEOUT_DEF    = 50000;

  localparam logic [PS2_BITS-1:0] PS2_BREAK = 8'hF0;
  localparam logic [PS2_BITS-1:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // True when data bits plus parity bit hold an odd number of ones.
  function automatic logic ps2_odd_ok(input logic [PS2_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin conditioning: 2-flop synchronizers plus a stability filter on the clock line.
// fall_o pulses 2 + FILTER_LEN cycles after a raw clock fall; no backpressure.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic dat_o,
  output logic clk_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic [7:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       fall_q, fall_d;
  logic       clk_s;

  assign clk_s = clk_sync_q[1];

  // Sync flops reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (clk_s == filt_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'(FILTER_LEN - 1)) begin
      filt_d = clk_s;
      cnt_d  = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 8'd0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

  assign dat_o  = dat_sync_q[1];
  assign clk_o  = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: 11-bit frame FSM with stall watchdog; strobe/err one cycle after the stop-bit fall,
// no backpressure. Define PS2_PARITY_CHECK_EN to drop odd-parity failures as ps2_err.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT    = PS2_TIMEOUT_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  output logic [PS2_BITS-1:0] ps2_data,
  output logic                ps2_data_clk,
  output logic                ps2_err
);

  logic dat_s;
  logic filt_clk;
  logic fall_raw;
  logic fall;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_i    (CLOCK_50),
    .rst_ni   (RESET_N),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .dat_o    (dat_s),
    .clk_o    (filt_clk),
    .fall_o   (fall_raw)
  );

  // The filter's fall pulse coincides with the filtered line being low.
  assign fall = fall_raw & ~filt_clk;

  ps2_state_e          state_q, state_d;
  logic [PS2_BITS-1:0] shift_q, shift_d;
  logic [PS2_BITS-1:0] data_q, data_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [15:0]         wdog_q, wdog_d;
  logic                strobe_q, strobe_d;
  logic                err_q, err_d;
  logic                timeout;
  logic                last_bit;
  logic                frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic                par_q, par_d;
`endif

  // Fires as the counter would step onto TIMEOUT-1; a coincident fall wins.
  assign timeout  = (state_q != ST_IDLE) && !fall && (wdog_q == 16'(TIMEOUT - 2));
  assign last_bit = (bitcnt_q == 3'(PS2_BITS - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dat_s & ps2_odd_ok({par_q, shift_q});
`else
  assign frame_ok = dat_s;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fall && last_bit) state_d = ST_PARITY;
        else if (timeout)     state_d = ST_IDLE;
      end
      ST_PARITY: begin
        if (fall)         state_d = ST_STOP;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_STOP: begin
        if (fall || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d  = shift_q;
    data_d   = data_q;
    bitcnt_d = bitcnt_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    wdog_d   = 16'd0;
`ifdef PS2_PARITY_CHECK_EN
    par_d    = par_q;
`endif
    if (state_q != ST_IDLE && !fall && !timeout) begin
      wdog_d = wdog_q + 16'd1;
    end
    if (timeout) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s) bitcnt_d = 3'd0;
      end
      ST_DATA: begin
        if (fall) begin
          shift_d[bitcnt_q] = dat_s;
          bitcnt_d          = bitcnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
        if (fall) par_d = dat_s;
`endif
      end
      ST_STOP: begin
        if (fall) begin
          if (frame_ok) begin
            data_d   = shift_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      shift_q  <= '0;
      data_q   <= '0;
      bitcnt_q <= 3'd0;
      wdog_q   <= 16'd0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      data_q   <= data_d;
      bitcnt_q <= bitcnt_d;
      wdog_q   <= wdog_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign ps2_data     = data_q;
  assign ps2_data_clk = strobe_q;
  assign ps2_err      = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good/bad frames, glitches, idle noise, watchdog timing and reset.
module tb_ps2_rx;

  localparam int F    = 8;
  localparam int T    = 200;
  localparam int HALF = 40;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] ps2_data;
  logic       ps2_data_clk;
  logic       ps2_err;

  ps2_rx #(
    .FILTER_LEN(F),
    .TIMEOUT   (T)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .ps2_data    (ps2_data),
    .ps2_data_clk(ps2_data_clk),
    .ps2_err     (ps2_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int         n_pass = 0;
  int         n_chk  = 0;
  int         n_strobe = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         n_bad_change = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge CLOCK_50) begin
    if (ps2_data_clk) begin
      n_strobe++;
      rx_q.push_back(ps2_data);
    end
    if (ps2_err) n_err++;
    if (ps2_data_clk && ps2_err) n_both++;
    if (RESET_N && (ps2_data !== prev_data) && !ps2_data_clk) n_bad_change++;
    prev_data = ps2_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered and left at #1 after a rising edge; data set during the high phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      repeat (10) @(posedge CLOCK_50);
      #1 ps2_clk = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1 ps2_clk = 1'b1;
      repeat (HALF - 13) @(posedge CLOCK_50);
      #1;
    end else begin
      repeat (HALF) @(posedge CLOCK_50);
      #1;
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge CLOCK_50);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(stop, 1'b0);
    ps2_dat = 1'b1;
    repeat (60) @(posedge CLOCK_50);
    #1;
  endtask

  int s0, e0;

  initial begin
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    RESET_N = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    check("reset_data", ps2_data, 8'h00);
    check("reset_strobe", ps2_data_clk, 1'b0);
    check("reset_err", ps2_err, 1'b0);
    RESET_N = 1'b1;
    repeat (20) @(posedge CLOCK_50);
    #1;

    // Good byte 0x1C, parity 0
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("1c_strobes", n_strobe - s0, 1);
    check("1c_data", ps2_data, 8'h1C);
    check("1c_err", n_err - e0, 0);

    // Back-to-back 0xF0 then 0x12
    s0 = n_strobe; e0 = n_err;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    check("b2b_strobes", n_strobe - s0, 2);
    check("b2b_first", rx_q[rx_q.size() - 2], 8'hF0);
    check("b2b_second", rx_q[rx_q.size() - 1], 8'h12);
    check("b2b_hold", ps2_data, 8'h12);
    check("b2b_err", n_err - e0, 0);

    // Wrong parity on 0x12
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_err", n_err - e0, 1);
    check("par_strobes", n_strobe - s0, 0);
`else
    check("par_err", n_err - e0, 0);
    check("par_strobes", n_strobe - s0, 1);
`endif
    check("par_data", ps2_data, 8'h12);

    // Stop bit 0 on 0x1C, then a good 0x1A
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("stop0_err", n_err - e0, 1);
    check("stop0_strobes", n_strobe - s0, 0);
    check("stop0_data", ps2_data, 8'h12);
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1A, 1'b0, 1'b1, 1'b0);
    check("after_stop0_strobes", n_strobe - s0, 1);
    check("after_stop0_data", ps2_data, 8'h1A);
    check("after_stop0_err", n_err - e0, 0);

    // 3-cycle clock glitches on every data/parity bit
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("glitch_strobes", n_strobe - s0, 1);
    check("glitch_data", ps2_data, 8'h1C);
    check("glitch_err", n_err - e0, 0);

    // Fall with data 1 in IDLE; a wrongly started frame would time out
    s0 = n_strobe; e0 = n_err;
    ps2_bit(1'b1, 1'b0);
    repeat (T + 50) @(posedge CLOCK_50);
    #1;
    check("noise_strobes", n_strobe - s0, 0);
    check("noise_err", n_err - e0, 0);

    // Stall after 4 data bits: err exactly T cycles after the last internal fall
    s0 = n_strobe; e0 = n_err;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    repeat (2 + F + T - 1 - HALF) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("stall_err_early", ps2_err, 1'b0);
    @(negedge CLOCK_50);
    check("stall_err_pulse", ps2_err, 1'b1);
    @(negedge CLOCK_50);
    check("stall_err_end", ps2_err, 1'b0);
    check("stall_strobes", n_strobe - s0, 0);
    @(posedge CLOCK_50);
    #1;
    s0 = n_strobe;
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    check("after_stall_strobes", n_strobe - s0, 1);
    check("after_stall_data", ps2_data, 8'h12);

    // Reset mid-frame
    s0 = n_strobe; e0 = n_err;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    RESET_N = 1'b0;
    #1;
    check("midrst_data", ps2_data, 8'h00);
    check("midrst_strobe", ps2_data_clk, 1'b0);
    check("midrst_err", ps2_err, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1 RESET_N = 1'b1;
    repeat (T + 50) @(posedge CLOCK_50);
    #1;
    check("midrst_no_strobe", n_strobe - s0, 0);
    check("midrst_no_err", n_err - e0, 0);
    check("midrst_data_after", ps2_data, 8'h00);

    check("strobe_err_overlap", n_both, 0);
    check("data_change_without_strobe", n_bad_change, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
